axis_telemetry_mux: RTL and testbench

- N-channel AXI-Stream framer/arbiter that merges several wide sensor sample streams into one 8-bit byte stream.
- Typical sources: accelerometer, future SPI/I2C sensors.
- Each accepted sample is emitted as one packet: a header byte (sequence number + channel id) followed by the sample bytes, with tlast on the final byte.
- Output feeds the COBS encoder → UART path, replacing the single-source direct hookup.

---
 rtl/axis_telemetry_mux.sv | 143 ++++++++++++++
 tb/tb_axis_telemetry_mux.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_telemetry_mux.sv
// axis_telemetry_mux
// Merges CHANNEL_COUNT wide AXI-Stream sample sources into a single byte stream.
// Each accepted sample becomes one packet: a header byte {seq, chan} followed by
// the sample bytes (least-significant byte first), with m_tlast on the final byte.
// Sources are granted round-robin, one packet at a time.
//
// Ports:
//   clk       system clock
//   reset     synchronous active-low reset
//   s_tdata   channel i sample at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_tvalid  per-channel valid
//   s_tready  per-channel ready, one-hot or zero, only while idle
//   m_tdata   output byte
//   m_tvalid  output valid
//   m_tready  downstream ready
//   m_tlast   high on the last payload byte of a packet
//   busy      high while a packet is held or being emitted
module axis_telemetry_mux #(
  parameter int unsigned CHANNEL_COUNT = 4,
  parameter int unsigned DATA_WIDTH    = 48,
  parameter bit          SEQ_ENABLE    = 1'b1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [CHANNEL_COUNT*DATA_WIDTH-1:0] s_tdata,
  input  logic [CHANNEL_COUNT-1:0]            s_tvalid,
  output logic [CHANNEL_COUNT-1:0]            s_tready,
  output logic [7:0]                          m_tdata,
  output logic                                m_tvalid,
  input  logic                                m_tready,
  output logic                                m_tlast,
  output logic                                busy
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned IW    = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;
  localparam int unsigned BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [IW-1:0] LastChan = IW'(CHANNEL_COUNT - 1);
  localparam logic [BW-1:0] LastByte = BW'(BYTES - 1);

  typedef enum logic [1:0] {StIdle, StHeader, StPayload} state_e;

  state_e                 state_q;
  logic [3:0]             seq_q;
  logic [IW-1:0]          last_q;
  logic [BW-1:0]          idx_q;
  logic [BW-1:0]          idx_next;
  logic [BYTES-1:0][7:0]  sample_q;

  logic [DATA_WIDTH-1:0]  chan_data [CHANNEL_COUNT];
  logic                   grant_any;
  logic [IW-1:0]          grant_idx;
  logic [IW-1:0]          cand_idx;
  int                     cand;

  for (genvar g = 0; g < CHANNEL_COUNT; g++) begin : g_unpack
    assign chan_data[g] = s_tdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search starting just above the last granted channel. Walking the
  // offsets from farthest to nearest lets the nearest valid channel win.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = int'(CHANNEL_COUNT); k >= 1; k--) begin
      cand     = (int'(last_q) + k) % int'(CHANNEL_COUNT);
      cand_idx = IW'(cand);
      if (s_tvalid[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  // Ready is gated by reset so a source never sees a handshake that the
  // reset would throw away.
  always_comb begin
    s_tready = '0;
    if (reset && (state_q == StIdle) && grant_any) begin
      s_tready[grant_idx] = 1'b1;
    end
  end

  assign idx_next = idx_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      seq_q    <= 4'h0;
      last_q   <= LastChan;
      idx_q    <= '0;
      sample_q <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tdata  <= 8'h00;
      busy     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_any) begin
            sample_q <= chan_data[grant_idx];
            last_q   <= grant_idx;
            idx_q    <= '0;
            state_q  <= StHeader;
            m_tvalid <= 1'b1;
            m_tlast  <= 1'b0;
            m_tdata  <= {(SEQ_ENABLE ? seq_q : 4'h0), 4'(grant_idx)};
            busy     <= 1'b1;
          end
        end
        StHeader: begin
          if (m_tready) begin
            state_q <= StPayload;
            idx_q   <= '0;
            m_tdata <= sample_q[0];
            m_tlast <= (BYTES == 1);
          end
        end
        StPayload: begin
          if (m_tready) begin
            if (idx_q == LastByte) begin
              state_q  <= StIdle;
              seq_q    <= seq_q + 4'h1;
              m_tvalid <= 1'b0;
              m_tlast  <= 1'b0;
              m_tdata  <= 8'h00;
              busy     <= 1'b0;
            end else begin
              idx_q   <= idx_next;
              m_tdata <= sample_q[idx_next];
              m_tlast <= (idx_next == LastByte);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_telemetry_mux.sv
// Testbench for axis_telemetry_mux: table-driven single packets, fairness,
// randomized backpressure against a packet-level reference model, sequence wrap,
// mid-packet reset and grant timing. A second instance runs with SEQ_ENABLE=0.
module tb_axis_telemetry_mux;

  localparam int N  = 4;
  localparam int DW = 48;
  localparam int NB = DW / 8;

  logic            clk;
  logic            reset;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tready, s_tready0;
  logic [7:0]      m_tdata, m_tdata0;
  logic            m_tvalid, m_tvalid0;
  logic            m_tready;
  logic            m_tlast, m_tlast0;
  logic            busy, busy0;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: expected {tlast, byte} beats, arbitration pointer,
  // packets accepted since reset.
  logic [8:0] exp_q[$];
  int         mdl_last;
  int         mdl_pkts;
  bit         first_beat;
  bit         prev_stall;
  logic [8:0] prev_out;

  axis_telemetry_mux #(.CHANNEL_COUNT(N), .DATA_WIDTH(DW), .SEQ_ENABLE(1'b1)) dut (
    .clk(clk), .reset(reset), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy)
  );

  axis_telemetry_mux #(.CHANNEL_COUNT(N), .DATA_WIDTH(DW), .SEQ_ENABLE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready0),
    .m_tdata(m_tdata0), .m_tvalid(m_tvalid0), .m_tready(m_tready), .m_tlast(m_tlast0),
    .busy(busy0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // First valid channel searching upward from last+1, wrapping.
  function automatic int pick(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (v[c[1:0]]) return c;
    end
    return -1;
  endfunction

  // Reference model and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      mdl_last   = N - 1;
      mdl_pkts   = 0;
      exp_q.delete();
      prev_stall = 1'b0;
      first_beat = 1'b1;
    end else begin
      logic [N-1:0] exp_rdy;
      int           w;
      logic [9:0]   e, e0;
      logic [DW-1:0] d;
      bit           idle;
      idle    = (exp_q.size() == 0);
      exp_rdy = '0;
      w       = pick(s_tvalid, mdl_last);
      if (idle && w >= 0) exp_rdy[w[1:0]] = 1'b1;
      check("s_tready", s_tready, exp_rdy);
      check("s_tready_noseq", s_tready0, exp_rdy);
      check("busy", busy, !idle);
      check("m_tvalid", m_tvalid, !idle);
      check("busy_noseq", busy0, !idle);
      if (prev_stall) check("hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_out});
      prev_stall = m_tvalid && !m_tready;
      prev_out   = {m_tlast, m_tdata};
      if (m_tvalid && m_tready) begin
        e  = (exp_q.size() != 0) ? {1'b0, exp_q.pop_front()} : 10'h3FF;
        e0 = first_beat ? {e[9:8], 4'h0, e[3:0]} : e;
        check("beat", {1'b0, m_tlast, m_tdata}, e);
        check("beat_noseq", {1'b0, m_tlast0, m_tdata0}, e0);
        first_beat = e[8];
      end
      if (exp_rdy != '0) begin
        d = s_tdata[w*DW +: DW];
        exp_q.push_back({1'b0, 4'(mdl_pkts % 16), 4'(w)});
        for (int b = 0; b < NB; b++) exp_q.push_back({(b == NB - 1), d[b*8 +: 8]});
        mdl_last = w;
        mdl_pkts++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    s_tvalid = '0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic drain();
    s_tvalid = '0;
    m_tready = 1'b1;
    for (int i = 0; i < 100 && (exp_q.size() != 0 || busy); i++) tick();
    @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 0);
    tick();
  endtask

  // Offer one sample on ch until accepted, then follow its packet to tlast.
  task automatic send_one(input int ch, input logic [DW-1:0] d, output logic [7:0] hdr,
                          output int nrdy, output int nbeats, output int nlast);
    s_tvalid[ch[1:0]]    = 1'b1;
    s_tdata[ch*DW +: DW] = d;
    hdr = 8'h00; nrdy = 0; nbeats = 0; nlast = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (s_tready[ch[1:0]]) nrdy++;
      if (m_tvalid && m_tready) begin
        if (nbeats == 0) hdr = m_tdata;
        nbeats++;
        if (m_tlast) nlast++;
      end
      tick();
      if (nrdy > 0) s_tvalid[ch[1:0]] = 1'b0;
      if (nlast > 0) break;
    end
  endtask

  typedef struct {
    int          ch;
    logic [DW-1:0] data;
    logic [7:0]  hdr;
  } vec_t;

  initial begin
    vec_t          vecs [4];
    logic [7:0]    fair_exp [6];
    logic [7:0]    hdrs[$];
    logic [7:0]    hdr;
    int            nrdy, nbeats, nlast, nl, nb;
    bit            fb, accd;
    logic [N-1:0]  pend, acc;
    int            first_v, first_l, next_r;

    vecs[0] = '{2, 48'h665544332211, 8'h02};
    vecs[1] = '{0, 48'hDEADBEEFCAFE, 8'h10};
    vecs[2] = '{3, 48'h0123456789AB, 8'h23};
    vecs[3] = '{1, 48'hFFEE00112233, 8'h31};
    fair_exp = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h40, 8'h51};

    reset    = 1'b0;
    s_tdata  = '0;
    s_tvalid = '1;
    m_tready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_busy", busy, 0);
    tick();
    s_tvalid = '0;
    reset    = 1'b1;
    m_tready = 1'b1;
    tick();

    // Table-driven single packets.
    for (int i = 0; i < 4; i++) begin
      send_one(vecs[i].ch, vecs[i].data, hdr, nrdy, nbeats, nlast);
      check("tbl_hdr", hdr, vecs[i].hdr);
      check("tbl_ready_cycles", 64'(nrdy), 1);
      check("tbl_beats", 64'(nbeats), NB + 1);
      check("tbl_tlast_count", 64'(nlast), 1);
    end
    drain();

    // Fairness: all channels valid continuously.
    do_reset();
    for (int c = 0; c < N; c++) s_tdata[c*DW +: DW] = 48'({$urandom(), $urandom()});
    s_tvalid = '1;
    fb = 1'b1; nl = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_tvalid && m_tready) begin
        if (fb) hdrs.push_back(m_tdata);
        fb = m_tlast;
        if (m_tlast) nl++;
      end
      tick();
      if (nl == 6) break;
    end
    s_tvalid = '0;
    check("fair_count", 64'(hdrs.size()), 6);
    for (int i = 0; i < 6; i++)
      check("fair_hdr", (i < hdrs.size()) ? 16'(hdrs[i]) : 16'hFFFF, 16'(fair_exp[i]));
    drain();

    // Randomized traffic with 50% backpressure.
    pend = '0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      acc = s_tvalid & s_tready;
      tick();
      for (int c = 0; c < N; c++) begin
        if (acc[c]) pend[c] = 1'b0;
        if (!pend[c] && $urandom_range(3) == 0) begin
          pend[c] = 1'b1;
          s_tdata[c*DW +: DW] = 48'({$urandom(), $urandom()});
        end
      end
      s_tvalid = pend;
      m_tready = 1'($urandom_range(1));
    end
    @(negedge clk);
    acc = s_tvalid & s_tready;
    tick();
    drain();

    // Sequence wrap over 17 packets on ch0.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send_one(0, 48'({$urandom(), $urandom()}), hdr, nrdy, nbeats, nlast);
      check("seq_hdr", hdr, {4'(i % 16), 4'h0});
    end
    drain();

    // Reset after the third payload byte.
    do_reset();
    s_tvalid[2] = 1'b1;
    s_tdata[2*DW +: DW] = 48'hA1A2A3A4A5A6;
    nb = 0; accd = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (s_tready[2]) accd = 1'b1;
      if (m_tvalid && m_tready) nb++;
      tick();
      if (accd) s_tvalid[2] = 1'b0;
      if (nb == 4) break;
    end
    reset    = 1'b0;
    s_tvalid = 4'b1001;
    tick();
    @(negedge clk);
    check("mid_rst_m_tvalid", m_tvalid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_s_tready", s_tready, 0);
    check("mid_rst_m_tlast", m_tlast, 0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_grant", s_tready, 4'b0001);
    tick();
    s_tvalid = '0;
    @(negedge clk);
    check("post_rst_hdr", {m_tvalid, m_tdata}, {1'b1, 8'h00});
    tick();
    drain();

    // Grant timing with s_tvalid[1] held.
    s_tvalid[1] = 1'b1;
    s_tdata[DW +: DW] = 48'h0F1E2D3C4B5A;
    first_v = -1; first_l = -1; next_r = -1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("gt_ready_same_cycle", s_tready[1], 1);
        check("gt_no_valid_yet", m_tvalid, 0);
      end
      if (m_tvalid && first_v < 0) first_v = c;
      if (m_tlast && first_l < 0) first_l = c;
      if (c > 0 && s_tready[1] && next_r < 0) next_r = c;
      tick();
      if (next_r >= 0) break;
    end
    s_tvalid = '0;
    check("gt_header_cycle", 64'(first_v), 1);
    check("gt_tlast_cycle", 64'(first_l), 7);
    check("gt_next_ready_cycle", 64'(next_r), 8);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
